apb_uart_slave: RTL and testbench
=================================

APB_UART_SLAVE -- requirements
Module: apb_uart_slave

Interface
REQ-001 Parameter DATA_W, default 32, APB data/request data width.
REQ-002 Parameter ADDR_W, default 16, APB address width.
REQ-003 Parameter REG_AW, default 5, local register window byte-address bits; window = paddr[ADDR_W-1:REG_AW] all ones.
REQ-004 Parameter TIMEOUT, default 255, max wait cycles per remote transfer; 0 disables timeout.
REQ-005 Clock and reset: reset reset, asynchronous, active-low; clock apb_clk.
REQ-006 psel, penable, pwrite  in  1  APB controls.
REQ-007 paddr  in  ADDR_W  APB address; pwdata  in  DATA_W  APB write data.
REQ-008 pready  out  1; prdata  out  DATA_W; pslverr  out  1  APB completion/read data/error.
REQ-009 req_valid  out  1; req_ready  in  1  request handshake to UART TX FIFO.
REQ-010 req_wr  out  1; req_addr  out  ADDR_W; req_data  out  DATA_W  request payload.
REQ-011 rsp_valid  in  1; rsp_data  in  DATA_W; rsp_err  in  1  read response from UART RX path.
REQ-012 reg_addr  out  REG_AW; reg_wdata  out  DATA_W; reg_we  out  1; reg_re  out  1; reg_rdata  in  DATA_W  local register file port.
REQ-013 stray_rsp  out  1  sticky flag: rsp_valid seen outside WAIT_RSP.

Function
REQ-014 FSM states IDLE, LOCAL, REQ, WAIT_RSP, DONE; one transfer in flight.
REQ-015 IDLE: on psel & !penable, go LOCAL if address in window, else REQ; else stay.
REQ-016 LOCAL (access cycle): reg_we=pwrite, reg_re=!pwrite, reg_addr=paddr[REG_AW-1:0], reg_wdata=pwdata, pready=1, pslverr=0, prdata=reg_rdata (same cycle, combinational); next IDLE. Zero wait states.
REQ-017 REQ: req_valid=1, req_wr=pwrite, req_addr=paddr, req_data=pwdata if write else 0; payload stable while req_valid & !req_ready.
REQ-018 REQ with req_ready: write -> DONE with err=0; read -> WAIT_RSP. Exactly one accepted request per APB transfer.
REQ-019 WAIT_RSP: on rsp_valid capture rsp_data and rsp_err into registers, go DONE.
REQ-020 DONE: pready=1, prdata=captured data (0 for writes), pslverr=captured err; next IDLE.
REQ-021 Timeout counter clears on entry to REQ, increments each cycle in REQ/WAIT_RSP, saturates; reaching TIMEOUT -> DONE with pslverr=1, prdata=0, req_valid low from that cycle.
REQ-022 Timeout and handshake/response in same cycle: handshake/response wins.
REQ-023 psel low in REQ or WAIT_RSP: abort to IDLE next cycle, req_valid drops; later response counts as stray.
REQ-024 rsp_valid in any state except WAIT_RSP: ignored, stray_rsp set until reset.
REQ-025 pready low in all states except LOCAL and DONE; reg_we/reg_re high only in LOCAL; req_valid high only in REQ.
REQ-026 Back-to-back transfers: new setup phase accepted in the IDLE cycle following LOCAL/DONE.

Reset
REQ-027 Reset asserted: state IDLE; pready, pslverr, req_valid, req_wr, reg_we, reg_re, stray_rsp = 0; prdata, req_addr, req_data, reg_addr, reg_wdata, captured data/err, timeout counter = 0.
REQ-028 Reset mid-transfer: immediate return to IDLE, no request or response retained.

Structure
REQ-029 Shared package apb_uart_pkg holds the FSM state enum and the request payload struct {wr, addr, data}.
REQ-030 Timeout counter is sub-module apb_uart_timer (clear, enable, expired; width $clog2(TIMEOUT+1)).

Verification
REQ-031 Local write paddr=0xFFE4, pwdata=0xA5A5A5A5 -> reg_we 1 cycle, reg_addr=0x04, pready in first access cycle.
REQ-032 Remote write paddr=0x0010, req_ready held low 3 cycles -> req_valid 4 cycles, single acceptance, pready one cycle after acceptance, pslverr=0.
REQ-033 Remote read paddr=0x0020, rsp_valid after 5 cycles with rsp_data=0x12345678 -> prdata=0x12345678, pready one cycle later.
REQ-034 Remote read, no response, TIMEOUT=8 -> pready with pslverr=1, prdata=0 after 8 wait cycles; later rsp_valid sets stray_rsp.
REQ-035 Reset asserted while in WAIT_RSP -> all outputs zero, state IDLE; next remote read completes normally.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared types for the APB-to-UART bridge: FSM state encoding and the
// remote request payload carried towards the UART TX FIFO.
package apb_uart_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOCAL    = 3'd1,
    REQ      = 3'd2,
    WAIT_RSP = 3'd3,
    DONE     = 3'd4
  } uart_state_e;

  typedef struct packed {
    logic                  wr;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
  } uart_req_t;

  // Read requests carry no data, so the payload is zeroed for them.
  function automatic uart_req_t make_req(input logic                  wr,
                                         input logic [APB_ADDR_W-1:0] addr,
                                         input logic [APB_DATA_W-1:0] data);
    uart_req_t r;
    r.wr   = wr;
    r.addr = addr;
    r.data = wr ? data : '0;
    return r;
  endfunction

endpackage

// File: rtl/apb_uart_slave_if.sv
// APB completer-side bus bundle; the master modport is the bus driver,
// the slave modport is the bridge.
interface apb_uart_slave_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_uart_timer.sv
// Saturating wait-cycle counter for remote transfers; expired_o flags the
// last permitted wait cycle. TIMEOUT of 0 never expires.
module apb_uart_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic apb_clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, then saturating increment while enabled.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q < SAT)) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge apb_clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The cycle holding count TIMEOUT-1 is the TIMEOUT-th wait cycle.
  assign expired_o = (TIMEOUT > 0) && enable_i && (count_q >= LAST);

endmodule

// File: rtl/apb_uart_slave.sv
// APB completer that serves a local register window with zero wait states
// and forwards all other accesses to the UART request/response path.
module apb_uart_slave
  import apb_uart_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              apb_clk,
  input  logic              reset,
  apb_uart_slave_if.slave   apb,

  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_wr_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_data_o,

  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  input  logic              rsp_err_i,

  output logic [REG_AW-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,

  output logic              stray_rsp_o
);

  uart_state_e       state_q, state_d;
  uart_req_t         req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              stray_q;

  logic              in_win_s;
  logic              setup_s;
  logic              tmr_clear_s;
  logic              tmr_en_s;
  logic              expired_s;

  assign in_win_s    = &apb.paddr[ADDR_W-1:REG_AW];
  assign setup_s     = apb.psel && !apb.penable;
  assign stray_rsp_o = stray_q;

  apb_uart_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .apb_clk   (apb_clk),
    .reset     (reset),
    .clear_i   (tmr_clear_s),
    .enable_i  (tmr_en_s),
    .expired_o (expired_s)
  );

  // Next-state and output decode; abort beats handshake beats timeout.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    reg_we_o    = 1'b0;
    reg_re_o    = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    req_valid_o = 1'b0;
    req_wr_o    = 1'b0;
    req_addr_o  = '0;
    req_data_o  = '0;

    case (state_q)
      IDLE: begin
        if (setup_s && in_win_s) begin
          state_d = LOCAL;
        end else if (setup_s) begin
          state_d     = REQ;
          tmr_clear_s = 1'b1;
          req_d       = make_req(apb.pwrite, APB_ADDR_W'(apb.paddr),
                                 APB_DATA_W'(apb.pwdata));
        end else begin
          state_d = IDLE;
        end
      end

      LOCAL: begin
        reg_we_o    = apb.pwrite;
        reg_re_o    = !apb.pwrite;
        reg_addr_o  = apb.paddr[REG_AW-1:0];
        reg_wdata_o = apb.pwdata;
        apb.pready  = 1'b1;
        apb.prdata  = reg_rdata_i;
        state_d     = IDLE;
      end

      REQ: begin
        tmr_en_s    = 1'b1;
        req_valid_o = 1'b1;
        req_wr_o    = req_q.wr;
        req_addr_o  = ADDR_W'(req_q.addr);
        req_data_o  = DATA_W'(req_q.data);
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (req_ready_i && req_q.wr) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b0;
        end else if (req_ready_i) begin
          state_d = WAIT_RSP;
        end else if (expired_s) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          state_d = REQ;
        end
      end

      WAIT_RSP: begin
        tmr_en_s = 1'b1;
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (rsp_valid_i) begin
          state_d = DONE;
          rdata_d = rsp_data_i;
          err_d   = rsp_err_i;
        end else if (expired_s) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT_RSP;
        end
      end

      DONE: begin
        apb.pready  = 1'b1;
        apb.prdata  = rdata_q;
        apb.pslverr = err_q;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request payload and captured completion.
  always_ff @(posedge apb_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Any response arriving while nothing is waiting for it is latched.
  always_ff @(posedge apb_clk or negedge reset) begin
    if (!reset) begin
      stray_q <= 1'b0;
    end else if (rsp_valid_i && (state_q != WAIT_RSP)) begin
      stray_q <= 1'b1;
    end else begin
      stray_q <= stray_q;
    end
  end

endmodule

// File: tb/tb_apb_uart_slave.sv
// Directed bench for apb_uart_slave: local window accesses, remote
// write/read handshakes, response errors, timeout, stray responses, reset.
module tb_apb_uart_slave;

  logic        apb_clk = 1'b0;
  logic        reset   = 1'b0;

  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_we, reg_re, stray_rsp;

  int          n_checks = 0;
  int          n_fail   = 0;

  int          n_valid, n_acc, acc_k, done_k;
  logic [31:0] got_prdata, acc_addr, acc_data;
  logic        got_err, acc_wr;

  always #5 apb_clk = ~apb_clk;

  apb_uart_slave_if #(.ADDR_W(16), .DATA_W(32)) apb ();

  apb_uart_slave #(
    .DATA_W  (32),
    .ADDR_W  (16),
    .REG_AW  (5),
    .TIMEOUT (8)
  ) dut (
    .apb_clk     (apb_clk),
    .reset       (reset),
    .apb         (apb),
    .req_valid_o (req_valid),
    .req_ready_i (req_ready),
    .req_wr_o    (req_wr),
    .req_addr_o  (req_addr),
    .req_data_o  (req_data),
    .rsp_valid_i (rsp_valid),
    .rsp_data_i  (rsp_data),
    .rsp_err_i   (rsp_err),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_we_o    (reg_we),
    .reg_re_o    (reg_re),
    .reg_rdata_i (reg_rdata),
    .stray_rsp_o (stray_rsp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = 16'h0000;
    apb.pwdata  = 32'h0000_0000;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0000_0000;
    rsp_err     = 1'b0;
  endtask

  task automatic setup(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    @(posedge apb_clk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = data;
  endtask

  // k = 0 is the first access cycle; rsp_at < 0 means no response at all.
  task automatic run_remote(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                            input int rdy_at, input int rsp_at,
                            input logic [31:0] rdata, input logic rerr);
    setup(wr, addr, data);
    n_valid = 0; n_acc = 0; acc_k = -1; done_k = -1;
    got_prdata = 32'h0; got_err = 1'b0;
    acc_addr = 32'h0; acc_data = 32'h0; acc_wr = 1'b0;
    for (int k = 0; (k < 40) && (done_k < 0); k++) begin
      @(posedge apb_clk); #1;
      apb.penable = 1'b1;
      req_ready   = (k >= rdy_at);
      rsp_valid   = (k == rsp_at);
      rsp_data    = (k == rsp_at) ? rdata : 32'h0;
      rsp_err     = (k == rsp_at) && rerr;
      @(negedge apb_clk);
      if (req_valid) begin
        n_valid++;
        if (req_ready) begin
          n_acc++;
          acc_k    = k;
          acc_addr = {16'h0, req_addr};
          acc_data = req_data;
          acc_wr   = req_wr;
        end
      end
      if (apb.pready) begin
        done_k     = k;
        got_prdata = apb.prdata;
        got_err    = apb.pslverr;
      end
    end
    @(posedge apb_clk); #1;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reg_rdata = 32'hCAFE_F00D;

    // Reset state
    repeat (2) @(negedge apb_clk);
    check_eq("rst_pready",    {31'h0, apb.pready},  32'h0);
    check_eq("rst_pslverr",   {31'h0, apb.pslverr}, 32'h0);
    check_eq("rst_prdata",    apb.prdata,           32'h0);
    check_eq("rst_req_valid", {31'h0, req_valid},   32'h0);
    check_eq("rst_req_addr",  {16'h0, req_addr},    32'h0);
    check_eq("rst_reg_we",    {31'h0, reg_we},      32'h0);
    check_eq("rst_reg_re",    {31'h0, reg_re},      32'h0);
    check_eq("rst_stray",     {31'h0, stray_rsp},   32'h0);
    @(posedge apb_clk); #1;
    reset = 1'b1;

    // Local write at 0xFFE4, then a back-to-back local read at 0xFFE8
    setup(1'b1, 16'hFFE4, 32'hA5A5_A5A5);
    @(negedge apb_clk);
    check_eq("lw_setup_pready", {31'h0, apb.pready}, 32'h0);
    check_eq("lw_setup_we",     {31'h0, reg_we},     32'h0);
    @(posedge apb_clk); #1;
    apb.penable = 1'b1;
    @(negedge apb_clk);
    check_eq("lw_we",      {31'h0, reg_we},      32'h1);
    check_eq("lw_re",      {31'h0, reg_re},      32'h0);
    check_eq("lw_addr",    {27'h0, reg_addr},    32'h4);
    check_eq("lw_wdata",   reg_wdata,            32'hA5A5_A5A5);
    check_eq("lw_pready",  {31'h0, apb.pready},  32'h1);
    check_eq("lw_pslverr", {31'h0, apb.pslverr}, 32'h0);
    check_eq("lw_no_req",  {31'h0, req_valid},   32'h0);
    setup(1'b0, 16'hFFE8, 32'h0);
    @(negedge apb_clk);
    check_eq("b2b_idle_we",     {31'h0, reg_we},     32'h0);
    check_eq("b2b_idle_pready", {31'h0, apb.pready}, 32'h0);
    @(posedge apb_clk); #1;
    apb.penable = 1'b1;
    @(negedge apb_clk);
    check_eq("lr_re",     {31'h0, reg_re},     32'h1);
    check_eq("lr_we",     {31'h0, reg_we},     32'h0);
    check_eq("lr_addr",   {27'h0, reg_addr},   32'h8);
    check_eq("lr_prdata", apb.prdata,          32'hCAFE_F00D);
    check_eq("lr_pready", {31'h0, apb.pready}, 32'h1);
    @(posedge apb_clk); #1;
    drive_idle();
    @(negedge apb_clk);
    check_eq("lr_after_re",     {31'h0, reg_re},     32'h0);
    check_eq("lr_after_pready", {31'h0, apb.pready}, 32'h0);

    // Remote write, ready low for three cycles
    run_remote(1'b1, 16'h0010, 32'hDEAD_BEEF, 3, -1, 32'h0, 1'b0);
    check_eq("rw_valid_cycles", n_valid,           32'd4);
    check_eq("rw_accepts",      n_acc,             32'd1);
    check_eq("rw_acc_cycle",    acc_k,             32'd3);
    check_eq("rw_done_cycle",   done_k,            32'd4);
    check_eq("rw_addr",         acc_addr,          32'h0010);
    check_eq("rw_data",         acc_data,          32'hDEAD_BEEF);
    check_eq("rw_wr",           {31'h0, acc_wr},   32'h1);
    check_eq("rw_pslverr",      {31'h0, got_err},  32'h0);
    check_eq("rw_prdata",       got_prdata,        32'h0);

    // Remote read, response five cycles after acceptance
    run_remote(1'b0, 16'h0020, 32'h1111_1111, 0, 5, 32'h1234_5678, 1'b0);
    check_eq("rr_accepts",    n_acc,            32'd1);
    check_eq("rr_valid",      n_valid,          32'd1);
    check_eq("rr_wr",         {31'h0, acc_wr},  32'h0);
    check_eq("rr_addr",       acc_addr,         32'h0020);
    check_eq("rr_data_zero",  acc_data,         32'h0);
    check_eq("rr_done_cycle", done_k,           32'd6);
    check_eq("rr_prdata",     got_prdata,       32'h1234_5678);
    check_eq("rr_pslverr",    {31'h0, got_err}, 32'h0);

    // Remote read with error response
    run_remote(1'b0, 16'h0040, 32'h0, 0, 2, 32'h0BAD_F00D, 1'b1);
    check_eq("re_done_cycle", done_k,           32'd3);
    check_eq("re_prdata",     got_prdata,       32'h0BAD_F00D);
    check_eq("re_pslverr",    {31'h0, got_err}, 32'h1);

    // Remote read with no response: timeout after 8 wait cycles
    run_remote(1'b0, 16'h0030, 32'h0, 0, -1, 32'h0, 1'b0);
    check_eq("to_done_cycle", done_k,           32'd8);
    check_eq("to_pslverr",    {31'h0, got_err}, 32'h1);
    check_eq("to_prdata",     got_prdata,       32'h0);
    @(negedge apb_clk);
    check_eq("to_stray_before", {31'h0, stray_rsp}, 32'h0);
    @(posedge apb_clk); #1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h7777_7777;
    @(posedge apb_clk); #1;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    @(negedge apb_clk);
    check_eq("to_stray_set",  {31'h0, stray_rsp},  32'h1);
    check_eq("to_stray_idle", {31'h0, apb.pready}, 32'h0);

    // Reset asserted while waiting for a response
    setup(1'b0, 16'h0050, 32'h0);
    @(posedge apb_clk); #1;
    apb.penable = 1'b1;
    req_ready   = 1'b1;
    @(posedge apb_clk); #1;
    req_ready   = 1'b0;
    @(negedge apb_clk);
    check_eq("wr_wait_valid",  {31'h0, req_valid},  32'h0);
    check_eq("wr_wait_pready", {31'h0, apb.pready}, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_pready", {31'h0, apb.pready},  32'h0);
    check_eq("mid_rst_valid",  {31'h0, req_valid},   32'h0);
    check_eq("mid_rst_prdata", apb.prdata,           32'h0);
    check_eq("mid_rst_stray",  {31'h0, stray_rsp},   32'h0);
    check_eq("mid_rst_raddr",  {16'h0, req_addr},    32'h0);
    @(posedge apb_clk); #1;
    drive_idle();
    @(posedge apb_clk); #1;
    reset = 1'b1;

    run_remote(1'b0, 16'h0060, 32'h0, 0, 3, 32'h55AA_55AA, 1'b0);
    check_eq("post_rst_accepts", n_acc,              32'd1);
    check_eq("post_rst_done",    done_k,             32'd4);
    check_eq("post_rst_prdata",  got_prdata,         32'h55AA_55AA);
    check_eq("post_rst_pslverr", {31'h0, got_err},   32'h0);
    check_eq("post_rst_stray",   {31'h0, stray_rsp}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
